// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared state, opcode, funct, ALU and mux-select encodings (MC_JUMP_EN adds the jump select)
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,
        S_ADDIWB = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;

    localparam logic [2:0] ALU_ADD = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b010;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
`ifdef MC_JUMP_EN
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
`endif

    // States that own the memory port and therefore wait on mem_ready.
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - instruction/memory status inputs and datapath control outputs of the sequencer
interface mc_control_fsm_if;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        pc_en;
    logic        ir_write;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_control;
    logic [1:0]  pc_src;
    logic        instr_done;
    logic        illegal;
    logic        timeout;

    modport master (
        input  instr, zero, mem_ready,
        output pc_en, ir_write, iord, mem_read, mem_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_control, pc_src,
               instr_done, illegal, timeout
    );

    modport slave (
        output instr, zero, mem_ready,
        input  pc_en, ir_write, iord, mem_read, mem_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_control, pc_src,
               instr_done, illegal, timeout
    );
endinterface

// File: rtl/mc_alu_decode.sv
// rtl/mc_alu_decode.sv - R-type funct field to ALU operation code plus legality flag
module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o,
    output logic       funct_valid_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        funct_valid_o = 1'b1;
        case (funct_i)
            FN_ADD:  alu_control_o = ALU_ADD;
            FN_SUB:  alu_control_o = ALU_SUB;
            FN_AND:  alu_control_o = ALU_AND;
            FN_OR:   alu_control_o = ALU_OR;
            FN_XOR:  alu_control_o = ALU_XOR;
            default: funct_valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle MIPS control sequencer with memory-wait timeout and illegal trap
// Optional: define MC_JUMP_EN to decode J (opcode 000010) instead of trapping on it.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    mc_control_fsm_if.master bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [2:0] funct_alu;
    logic       funct_valid;
    logic       mem_wait;
    logic       limit_hit;
    logic       unused_instr_bits;

    assign opcode            = bus.instr[31:26];
    assign funct             = bus.instr[5:0];
    assign unused_instr_bits = ^bus.instr[25:6];

    mc_alu_decode u_alu_decode (
        .funct_i       (funct),
        .alu_control_o (funct_alu),
        .funct_valid_o (funct_valid)
    );

    // A request is pending only while a memory state sees no ready.
    assign mem_wait  = is_mem_state(state_q) && !bus.mem_ready;
    assign limit_hit = (WAIT_MAX != 0) && (cnt_q == CNT_W'(WAIT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R: begin
                        if (funct_valid) begin
                            state_d = S_EXEC;
                        end else begin
                            state_d   = S_TRAP;
                            illegal_d = 1'b1;
                        end
                    end
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J: begin
`ifdef MC_JUMP_EN
                        state_d = S_JUMP;
`else
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
`endif
                    end
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
`ifdef MC_JUMP_EN
            S_JUMP:   state_d = S_FETCH;
`endif
            default:  state_d = S_TRAP;
        endcase

        // Ready on the limit cycle already left the state above; only a miss traps.
        if (mem_wait) begin
            if (limit_hit) begin
                state_d   = S_TRAP;
                timeout_d = 1'b1;
            end else begin
                cnt_d = (cnt_q == CNT_W'(WAIT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
            end
        end
    end

    logic       pc_en_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c, instr_done_c;
    logic       iord_c, reg_dst_c, mem_to_reg_c, alu_src_a_c;
    logic [1:0] alu_src_b_c, pc_src_c;
    logic [2:0] alu_control_c;

    always_comb begin
        pc_en_c       = 1'b0;
        ir_write_c    = 1'b0;
        mem_read_c    = 1'b0;
        mem_write_c   = 1'b0;
        reg_write_c   = 1'b0;
        instr_done_c  = 1'b0;
        iord_c        = 1'b0;
        reg_dst_c     = 1'b0;
        mem_to_reg_c  = 1'b0;
        alu_src_a_c   = 1'b0;
        alu_src_b_c   = SRCB_RT;
        pc_src_c      = PC_SRC_ALU;
        alu_control_c = 3'b000;
        case (state_q)
            S_FETCH: begin
                mem_read_c    = 1'b1;
                alu_src_b_c   = SRCB_FOUR;
                alu_control_c = ALU_ADD;
                pc_src_c      = PC_SRC_ALU;
                ir_write_c    = bus.mem_ready;
                pc_en_c       = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_b_c   = SRCB_IMM_SH2;
                alu_control_c = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a_c   = 1'b1;
                alu_src_b_c   = SRCB_IMM;
                alu_control_c = ALU_ADD;
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg_c = 1'b1;
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            S_MEMWR: begin
                mem_write_c  = 1'b1;
                iord_c       = 1'b1;
                instr_done_c = bus.mem_ready;
            end
            S_EXEC: begin
                alu_src_a_c   = 1'b1;
                alu_src_b_c   = SRCB_RT;
                alu_control_c = funct_alu;
            end
            S_ALUWB: begin
                reg_dst_c    = 1'b1;
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            S_ADDIWB: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_c   = 1'b1;
                alu_src_b_c   = SRCB_RT;
                alu_control_c = ALU_SUB;
                pc_src_c      = PC_SRC_ALUOUT;
                pc_en_c       = bus.zero;
                instr_done_c  = 1'b1;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                pc_src_c     = PC_SRC_JUMP;
                pc_en_c      = 1'b1;
                instr_done_c = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Strobes are gated by reset directly so an asserted reset kills an access without waiting for a clock.
    assign bus.pc_en       = pc_en_c      & rst_n;
    assign bus.ir_write    = ir_write_c   & rst_n;
    assign bus.mem_read    = mem_read_c   & rst_n;
    assign bus.mem_write   = mem_write_c  & rst_n;
    assign bus.reg_write   = reg_write_c  & rst_n;
    assign bus.instr_done  = instr_done_c & rst_n;
    assign bus.iord        = iord_c;
    assign bus.reg_dst     = reg_dst_c;
    assign bus.mem_to_reg  = mem_to_reg_c;
    assign bus.alu_src_a   = alu_src_a_c;
    assign bus.alu_src_b   = alu_src_b_c;
    assign bus.alu_control = alu_control_c;
    assign bus.pc_src      = pc_src_c;
    assign bus.illegal     = illegal_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed and randomized checks of mc_control_fsm against a step-queue model
module tb_mc_control_fsm;

    typedef enum {F, D, MA, MR, MWB, MW, EX, AWB, AX, AIWB, BR, JP, TR} step_t;
    typedef struct {
        step_t s;
        logic  rdy;
        logic  ill;
        logic  to;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    mc_control_fsm_if bus();

    mc_control_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [18:0] obs_w;
    assign obs_w = {bus.illegal, bus.timeout, bus.pc_en, bus.ir_write, bus.iord, bus.mem_read,
                    bus.mem_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                    bus.alu_src_b, bus.alu_control, bus.pc_src, bus.instr_done};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b101;
            6'h22:   return 3'b110;
            6'h24:   return 3'b001;
            6'h25:   return 3'b011;
            6'h26:   return 3'b010;
            default: return 3'bxxx;
        endcase
    endfunction

    // Expected control outputs for one step, straight from the per-step output table.
    function automatic logic [16:0] word(input step_t s, input logic rdy, input logic z, input logic [5:0] fn);
        logic pe, irw, io, mr, mw, rd, m2r, rw, asa, id;
        logic [1:0] asb, ps;
        logic [2:0] ac;
        {pe, irw, io, mr, mw, rd, m2r, rw, asa, id} = '0;
        asb = 2'b00; ps = 2'b00; ac = 3'b000;
        case (s)
            F:    begin mr = 1; asb = 2'b01; ac = 3'b101; irw = rdy; pe = rdy; end
            D:    begin asb = 2'b11; ac = 3'b101; end
            MA:   begin asa = 1; asb = 2'b10; ac = 3'b101; end
            MR:   begin mr = 1; io = 1; end
            MWB:  begin m2r = 1; rw = 1; id = 1; end
            MW:   begin mw = 1; io = 1; id = rdy; end
            EX:   begin asa = 1; ac = alu_of(fn); end
            AWB:  begin rd = 1; rw = 1; id = 1; end
            AX:   begin asa = 1; asb = 2'b10; ac = 3'b101; end
            AIWB: begin rw = 1; id = 1; end
            BR:   begin asa = 1; ac = 3'b110; ps = 2'b01; pe = z; id = 1; end
            JP:   begin ps = 2'b10; pe = 1; id = 1; end
            default: ;
        endcase
        return {pe, irw, io, mr, mw, rd, m2r, rw, asa, asb, ac, ps, id};
    endfunction

    task automatic push(input step_t s, input logic rdy, input logic ill = 1'b0, input logic to = 1'b0);
        ent_t e;
        e.s = s; e.rdy = rdy; e.ill = ill; e.to = to;
        q.push_back(e);
    endtask

    task automatic push_mem(input step_t s, input int d);
        for (int i = 0; i < d; i++) push(s, 1'b0);
        push(s, 1'b1);
    endtask

    // Expected step sequence for one legal instruction with d0 fetch waits and d1 data waits.
    task automatic build(input logic [31:0] ins, input int d0, input int d1);
        push_mem(F, d0);
        push(D, 1'($urandom_range(0, 1)));
        case (ins[31:26])
            6'h00: begin push(EX, 1'($urandom_range(0, 1))); push(AWB, 1'($urandom_range(0, 1))); end
            6'h23: begin push(MA, 1'($urandom_range(0, 1))); push_mem(MR, d1); push(MWB, 1'($urandom_range(0, 1))); end
            6'h2B: begin push(MA, 1'($urandom_range(0, 1))); push_mem(MW, d1); end
            6'h08: begin push(AX, 1'($urandom_range(0, 1))); push(AIWB, 1'($urandom_range(0, 1))); end
            6'h04: push(BR, 1'($urandom_range(0, 1)));
            default: ;
        endcase
    endtask

    // Starts at posedge+1; drives each step, checks at negedge, returns at posedge+1.
    task automatic run(input string tag, input logic [31:0] ins, input logic z);
        int i = 0;
        ent_t e;
        bus.instr = ins;
        bus.zero  = z;
        while (q.size() > 0) begin
            e = q.pop_front();
            bus.mem_ready = e.rdy;
            @(negedge clk);
            chk($sformatf("%s[%0d]", tag, i), 32'(obs_w), 32'({e.ill, e.to, word(e.s, e.rdy, z, ins[5:0])}));
            @(posedge clk); #1;
            i++;
        end
    endtask

    task automatic rst_pulse(input string tag);
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_strobes"}, 32'({bus.pc_en, bus.ir_write, bus.reg_write, bus.mem_write,
                                    bus.mem_read, bus.instr_done}), 32'd0);
        chk({tag, "_sticky"}, 32'({bus.illegal, bus.timeout}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        logic        z;
        int          kind;
        logic [5:0]  fns [5];
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h26;

        rst_n = 1'b0;
        bus.instr = 32'h0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        rst_pulse("reset");

        build(32'h00221820, 0, 0);
        run("add", 32'h00221820, 1'b0);

        build(32'h8C220004, 0, 3);
        run("lw_wait3", 32'h8C220004, 1'b0);

        build(32'hAC220004, 0, 0);
        run("sw", 32'hAC220004, 1'b1);

        build(32'h20220005, 1, 0);
        run("addi", 32'h20220005, 1'b0);

        build(32'h10220003, 0, 0);
        run("beq_z1", 32'h10220003, 1'b1);
        build(32'h10220003, 0, 0);
        run("beq_z0", 32'h10220003, 1'b0);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0:       ins = {6'h00, 20'($urandom), fns[$urandom_range(0, 4)]};
                1:       ins = {6'h23, 26'($urandom)};
                2:       ins = {6'h2B, 26'($urandom)};
                3:       ins = {6'h08, 26'($urandom)};
                default: ins = {6'h04, 26'($urandom)};
            endcase
            z = 1'($urandom_range(0, 1));
            build(ins, $urandom_range(0, 4), $urandom_range(0, 4));
            run($sformatf("rand%0d", n), ins, z);
        end

`ifdef MC_JUMP_EN
        push(F, 1'b1); push(D, 1'b0); push(JP, 1'b0);
        build(32'h00221822, 0, 0);
        run("jump", 32'h08000010, 1'b0);
`else
        push(F, 1'b1); push(D, 1'b0);
        for (int i = 0; i < 3; i++) push(TR, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        run("j_illegal", 32'h08000010, 1'b0);
        rst_pulse("rst_j");
`endif

        push(F, 1'b1); push(D, 1'b1);
        for (int i = 0; i < 4; i++) push(TR, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        run("bad_op", 32'hFC000000, 1'b1);
        rst_pulse("rst_badop");

        push(F, 1'b1); push(D, 1'b0);
        for (int i = 0; i < 4; i++) push(TR, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        run("bad_fn", 32'h0022182A, 1'b1);
        rst_pulse("rst_badfn");

        for (int i = 0; i < 16; i++) push(F, 1'b0);
        for (int i = 0; i < 3; i++) push(TR, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        run("timeout", 32'h00221820, 1'b0);
        rst_pulse("rst_timeout");

        build(32'h00221820, 15, 0);
        run("ready_at_limit", 32'h00221820, 1'b0);

        push(F, 1'b1); push(D, 1'b0); push(MA, 1'b0);
        run("sw_pre", 32'hAC220004, 1'b0);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("mw_active", 32'(obs_w), 32'({2'b00, word(MW, 1'b0, 1'b0, 6'h04)}));
        #2 rst_n = 1'b0;
        #1;
        chk("mw_async_drop", 32'({bus.mem_write, bus.mem_read, bus.reg_write, bus.pc_en,
                                  bus.ir_write, bus.instr_done}), 32'd0);
        @(posedge clk); #1;
        chk("mw_rst_sticky", 32'({bus.illegal, bus.timeout, bus.mem_write}), 32'd0);
        rst_n = 1'b1;
        build(32'h00221824, 0, 0);
        run("after_rst", 32'h00221824, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
